// File: rtl/cpu_core_param_if.sv
// Fetch bus between the core and its program source: a req/valid handshake
// carrying one instruction or immediate word per accepted transfer.
interface cpu_core_param_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    logic              fetch_req;
    logic [PC_W-1:0]   fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;

    modport master (output fetch_req, fetch_addr, input fetch_valid, fetch_data);
    modport slave  (input fetch_req, fetch_addr, output fetch_valid, fetch_data);
endinterface

// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle accumulator CPU core with wait-state fetch.
// Define CPU_CORE_BRANCH_EN to enable JMP/JZ/JC; otherwise those opcodes are illegal.
module cpu_core_param #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    cpu_core_param_if.master    fetch,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                halted,
    output logic                error,
    output logic [PC_W-1:0]     pc
);
    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_IMM, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_t;

    state_t            state, state_next;
    logic [7:0]        ir;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] regs [NREGS];
    logic              flag_c, flag_z;
    logic [DATA_W-1:0] res_q;
    logic              res_c, res_z;

    logic [3:0]        op, r;
    logic [IDX_W-1:0]  ridx;
    logic              uses_r, r_oob, needs_imm, illegal;
    logic [DATA_W-1:0] operand, alu_res;
    logic              alu_c;
    logic [DATA_W:0]   sum, diff;

    assign op     = ir[7:4];
    assign r      = ir[3:0];
    assign ridx   = r[IDX_W-1:0];
    assign uses_r = (op >= OP_LDI) && (op <= OP_ST);
    assign r_oob  = ({28'd0, r} >= 32'(NREGS));

`ifdef CPU_CORE_BRANCH_EN
    logic            take_q;
    logic            take_next;
    logic [PC_W-1:0] target;

    assign needs_imm = (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    assign illegal   = (op == 4'hD) || (op == 4'hE) || (uses_r && r_oob);
    // Branch condition uses the flags committed by earlier instructions.
    assign take_next = (op == OP_JMP) || ((op == OP_JZ) && flag_z) || ((op == OP_JC) && flag_c);
    assign target    = PC_W'(imm);
`else
    assign needs_imm = (op == OP_LDI);
    assign illegal   = (op == 4'hD) || (op == 4'hE) || (uses_r && r_oob) ||
                       (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
`endif

    assign fetch.fetch_req  = ((state == S_FETCH) || (state == S_IMM)) && !rst;
    assign fetch.fetch_addr = pc;
    assign halted           = (state == S_HALT);

    assign operand = regs[ridx];
    assign sum     = {1'b0, acc} + {1'b0, operand};
    assign diff    = {1'b0, acc} - {1'b0, operand};

    always_comb begin
        alu_res = acc;
        alu_c   = flag_c;
        case (op)
            OP_MOV: alu_res = operand;
            OP_ADD: {alu_c, alu_res} = sum;
            OP_SUB: {alu_c, alu_res} = diff;
            OP_AND: begin alu_res = acc & operand; alu_c = 1'b0; end
            OP_OR:  begin alu_res = acc | operand; alu_c = 1'b0; end
            OP_XOR: begin alu_res = acc ^ operand; alu_c = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     if (fetch.fetch_valid) state_next = S_DECODE;
            S_DECODE: begin
                if (illegal || (op == OP_HLT)) state_next = S_HALT;
                else if (needs_imm)            state_next = S_IMM;
                else                           state_next = S_EXECUTE;
            end
            S_IMM:       if (fetch.fetch_valid) state_next = S_EXECUTE;
            S_EXECUTE:   state_next = S_WRITEBACK;
            S_WRITEBACK: state_next = S_FETCH;
            default:     state_next = S_HALT;
        endcase
    end

    // EXECUTE only fills the result registers; all architectural commits happen in WRITEBACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            ir        <= '0;
            imm       <= '0;
            acc       <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            res_q     <= '0;
            res_c     <= 1'b0;
            res_z     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            error     <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef CPU_CORE_BRANCH_EN
            take_q    <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_FETCH: if (fetch.fetch_valid) begin
                    ir <= fetch.fetch_data[7:0];
                    pc <= pc + PC_W'(1);
                end
                S_DECODE: if (illegal) error <= 1'b1;
                S_IMM: if (fetch.fetch_valid) begin
                    imm <= fetch.fetch_data;
                    pc  <= pc + PC_W'(1);
                end
                S_EXECUTE: begin
                    res_q <= alu_res;
                    res_c <= alu_c;
                    res_z <= (alu_res == '0);
`ifdef CPU_CORE_BRANCH_EN
                    take_q <= take_next;
`endif
                end
                S_WRITEBACK: begin
                    case (op)
                        OP_LDI: regs[ridx] <= imm;
                        OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            acc    <= res_q;
                            flag_c <= res_c;
                            flag_z <= res_z;
                        end
                        OP_ST:  regs[ridx] <= acc;
                        OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
`ifdef CPU_CORE_BRANCH_EN
                    if (take_q) pc <= target;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core_param.sv
// Directed testbench for cpu_core_param: a main 8-bit core with a wait-state
// program responder, plus a PC_W=4 instance fed NOPs for the wrap check.
module tb_cpu_core_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_core_param_if #(.DATA_W(8), .PC_W(8)) bus ();
    cpu_core_param_if #(.DATA_W(8), .PC_W(4)) bus_w ();

    logic [7:0] out_data, w_out_data;
    logic       out_valid, halted, error, w_out_valid, w_halted, w_error;
    logic [7:0] pc;
    logic [3:0] w_pc;

    cpu_core_param #(.DATA_W(8), .NREGS(4), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .fetch(bus), .out_data(out_data),
        .out_valid(out_valid), .halted(halted), .error(error), .pc(pc)
    );

    cpu_core_param #(.DATA_W(8), .NREGS(4), .PC_W(4)) dut_w (
        .clk(clk), .rst(rst), .fetch(bus_w), .out_data(w_out_data),
        .out_valid(w_out_valid), .halted(w_halted), .error(w_error), .pc(w_pc)
    );

    logic [7:0] prog [256];
    int         wp;
    int         wait_states = 0;
    int         total = 0;
    int         bad = 0;

    assign bus.fetch_data   = prog[bus.fetch_addr];
    assign bus_w.fetch_data = 8'h00;

    // Program responder: each new request waits wait_states cycles before valid.
    initial begin
        int         cnt;
        bit         pending;
        logic [7:0] held;
        cnt = 0; pending = 0; held = '0;
        bus.fetch_valid   = 1'b0;
        bus_w.fetch_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (!bus.fetch_req) begin
                bus.fetch_valid = 1'b0;
                pending = 0;
            end else begin
                if (!pending) begin
                    pending = 1;
                    cnt = wait_states;
                    held = bus.fetch_addr;
                end else begin
                    total++;
                    if (bus.fetch_addr !== held) begin
                        bad++;
                        $display("[TB] FAIL addr_stable: got %h want %h", bus.fetch_addr, held);
                    end
                end
                if (cnt == 0) bus.fetch_valid = 1'b1;
                else begin
                    bus.fetch_valid = 1'b0;
                    cnt--;
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
        wp = 0;
    endtask

    task automatic emit(input logic [7:0] b);
        prog[wp] = b;
        wp++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Reset, release, and count edges until halted; also records OUT pulses.
    task automatic run_prog(input int ws, output int n_halt, output int n_pulse, output int pulses);
        int n;
        wait_states = ws;
        do_reset();
        n = 0; n_pulse = -1; pulses = 0;
        while (!halted && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) begin
                pulses++;
                if (n_pulse < 0) n_pulse = n;
            end
        end
        n_halt = n;
        total++;
        if (!halted) begin
            bad++;
            $display("[TB] FAIL halt_timeout: got %0d cycles without halt want halt", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.fetch_req, bus.fetch_addr, pc, out_data, out_valid, halted, error} !== 27'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want 0",
                     {bus.fetch_req, bus.fetch_addr, pc, out_data, out_valid, halted, error});
        end
        total++;
        if ({dut.acc, dut.flag_c, dut.flag_z} !== 10'd0) begin
            bad++;
            $display("[TB] FAIL reset_acc_flags: got %h want 0", {dut.acc, dut.flag_c, dut.flag_z});
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.fetch_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_req_rise: got %b want 1", bus.fetch_req);
        end
    endtask

    task automatic straight_program();
        clear_prog();
        emit(8'h10); emit(8'h05); emit(8'h11); emit(8'h03);
        emit(8'h20); emit(8'h31); emit(8'h90); emit(8'hF0);
    endtask

    task automatic check_straight(input string tag, input int nh, input int np, input int pl,
                                  input int want_h, input int want_p);
        total++;
        if (nh !== want_h) begin
            bad++; $display("[TB] FAIL %s_halt_cycle: got %0d want %0d", tag, nh, want_h);
        end
        total++;
        if (np !== want_p || pl !== 1) begin
            bad++; $display("[TB] FAIL %s_pulse: got cycle %0d count %0d want cycle %0d count 1", tag, np, pl, want_p);
        end
        total++;
        if (out_data !== 8'h08) begin
            bad++; $display("[TB] FAIL %s_out: got %h want 08", tag, out_data);
        end
        total++;
        if ({dut.flag_z, dut.flag_c, error, pc} !== {3'b000, 8'd8}) begin
            bad++; $display("[TB] FAIL %s_flags_pc: got z%b c%b e%b pc%h want z0 c0 e0 pc08",
                            tag, dut.flag_z, dut.flag_c, error, pc);
        end
    endtask

    task automatic test_straight();
        int nh, np, pl;
        straight_program();
        run_prog(0, nh, np, pl);
        // HLT sits at address 7, so pc reads 8 once halted.
        check_straight("straight", nh, np, pl, 24, 22);
    endtask

    task automatic test_wait_states();
        int nh, np, pl;
        straight_program();
        run_prog(3, nh, np, pl);
        check_straight("wait", nh, np, pl, 48, 43);
        wait_states = 0;
    endtask

    task automatic test_carry();
        int nh, np, pl;
        clear_prog();
        emit(8'h10); emit(8'hFF); emit(8'h11); emit(8'h01);
        emit(8'h20); emit(8'h31); emit(8'hF0);
        run_prog(0, nh, np, pl);
        total++;
        if ({dut.acc, dut.flag_z, dut.flag_c} !== {8'h00, 2'b11}) begin
            bad++; $display("[TB] FAIL add_carry: got acc%h z%b c%b want acc00 z1 c1", dut.acc, dut.flag_z, dut.flag_c);
        end
        clear_prog();
        emit(8'h10); emit(8'hFF); emit(8'h11); emit(8'h01);
        emit(8'h20); emit(8'h31); emit(8'h41); emit(8'h90); emit(8'hF0);
        run_prog(0, nh, np, pl);
        total++;
        if ({out_data, dut.flag_z, dut.flag_c} !== {8'hFF, 2'b01}) begin
            bad++; $display("[TB] FAIL sub_borrow: got out%h z%b c%b want outff z0 c1", out_data, dut.flag_z, dut.flag_c);
        end
    endtask

    task automatic test_logic();
        int nh, np, pl;
        clear_prog();
        emit(8'h10); emit(8'hCA); emit(8'h11); emit(8'h0F);
        emit(8'h21); emit(8'h40); emit(8'h83);
        emit(8'h20); emit(8'h51); emit(8'h82);
        emit(8'h20); emit(8'h61); emit(8'h90);
        emit(8'h20); emit(8'h71); emit(8'hF0);
        run_prog(0, nh, np, pl);
        total++;
        if (dut.regs[3] !== 8'h45) begin
            bad++; $display("[TB] FAIL sub_result: got %h want 45", dut.regs[3]);
        end
        total++;
        if (dut.regs[2] !== 8'h0A) begin
            bad++; $display("[TB] FAIL and_result: got %h want 0a", dut.regs[2]);
        end
        total++;
        if (out_data !== 8'hCF) begin
            bad++; $display("[TB] FAIL or_result: got %h want cf", out_data);
        end
        total++;
        if ({dut.acc, dut.flag_c, dut.flag_z} !== {8'hC5, 2'b00}) begin
            bad++; $display("[TB] FAIL xor_result: got acc%h c%b z%b want accc5 c0 z0", dut.acc, dut.flag_c, dut.flag_z);
        end
    endtask

    task automatic test_back_to_back();
        int nh, np, pl;
        clear_prog();
        emit(8'h10); emit(8'h03); emit(8'h20); emit(8'h90); emit(8'h90); emit(8'hF0);
        run_prog(0, nh, np, pl);
        total++;
        if (pl !== 2 || np !== 13 || out_data !== 8'h03 || pc !== 8'd6) begin
            bad++; $display("[TB] FAIL b2b_out: got count %0d first %0d data %h pc %h want 2 13 03 06", pl, np, out_data, pc);
        end
    endtask

    task automatic test_branch();
        int nh, np, pl;
`ifdef CPU_CORE_BRANCH_EN
        clear_prog();
        emit(8'h10); emit(8'h00); emit(8'h20); emit(8'hB0); emit(8'h20); emit(8'hD0);
        prog[8'h20] = 8'hF0;
        do_reset();
        repeat (14) begin @(posedge clk); #1; end
        total++;
        if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 8'h20) begin
            bad++; $display("[TB] FAIL jz_taken: got req%b addr%h want req1 addr20", bus.fetch_req, bus.fetch_addr);
        end
        clear_prog();
        emit(8'h10); emit(8'h01); emit(8'h20); emit(8'hB0); emit(8'h20); emit(8'hF0);
        prog[8'h20] = 8'h25;
        do_reset();
        repeat (14) begin @(posedge clk); #1; end
        total++;
        if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 8'h05) begin
            bad++; $display("[TB] FAIL jz_not_taken: got req%b addr%h want req1 addr05", bus.fetch_req, bus.fetch_addr);
        end
`else
        clear_prog();
        emit(8'h10); emit(8'h00); emit(8'h20); emit(8'hB0); emit(8'h20);
        run_prog(0, nh, np, pl);
        total++;
        if (nh !== 11 || error !== 1'b1 || pc !== 8'h04) begin
            bad++; $display("[TB] FAIL jz_illegal: got cycle %0d err%b pc%h want 11 1 04", nh, error, pc);
        end
`endif
    endtask

    task automatic test_illegal();
        int  nh, np, pl;
        bit  req_seen;
        clear_prog();
        emit(8'h25);
        run_prog(0, nh, np, pl);
        total++;
        if (nh !== 2 || error !== 1'b1 || pc !== 8'h01) begin
            bad++; $display("[TB] FAIL mov_r5_illegal: got cycle %0d err%b pc%h want 2 1 01", nh, error, pc);
        end
        req_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.fetch_req !== 1'b0 || halted !== 1'b1) req_seen = 1;
        end
        total++;
        if (req_seen) begin
            bad++; $display("[TB] FAIL halt_absorbing: got activity want none");
        end
        clear_prog();
        emit(8'hD0);
        run_prog(0, nh, np, pl);
        total++;
        if (error !== 1'b1) begin
            bad++; $display("[TB] FAIL op_d_illegal: got err%b want 1", error);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (60) begin @(posedge clk); #1; end
        total++;
        if (bus_w.fetch_req !== 1'b1 || bus_w.fetch_addr !== 4'hF) begin
            bad++; $display("[TB] FAIL wrap_pre: got req%b addr%h want req1 addrf", bus_w.fetch_req, bus_w.fetch_addr);
        end
        @(posedge clk); #1;
        total++;
        if (w_pc !== 4'h0) begin
            bad++; $display("[TB] FAIL wrap_pc: got %h want 0", w_pc);
        end
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (bus_w.fetch_req !== 1'b1 || bus_w.fetch_addr !== 4'h0) begin
            bad++; $display("[TB] FAIL wrap_post: got req%b addr%h want req1 addr0", bus_w.fetch_req, bus_w.fetch_addr);
        end
    endtask

    task automatic test_reset_mid();
        clear_prog();
        emit(8'h10); emit(8'h55); emit(8'hF0);
        do_reset();
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (bus.fetch_req !== 1'b1 || pc !== 8'h01) begin
            bad++; $display("[TB] FAIL mid_imm_state: got req%b pc%h want req1 pc01", bus.fetch_req, pc);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.fetch_req, bus.fetch_addr, pc, out_valid, halted, error, dut.regs[0]} !== 28'd0) begin
            bad++; $display("[TB] FAIL mid_reset: got req%b addr%h pc%h ov%b h%b e%b r0%h want all 0",
                            bus.fetch_req, bus.fetch_addr, pc, out_valid, halted, error, dut.regs[0]);
        end
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        total++;
        if (dut.regs[0] !== 8'h55) begin
            bad++; $display("[TB] FAIL mid_restart: got r0 %h want 55", dut.regs[0]);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_straight();
        test_wait_states();
        test_carry();
        test_logic();
        test_back_to_back();
        test_branch();
        test_illegal();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
